// File: rtl/feistel_block_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : feistel_block_core
// Purpose  : Iterative Feistel block cipher engine. It executes one round
//            per clock and supports encrypt/decrypt plus optional CBC
//            chaining across successive blocks.
// Ports    : clk, rst (sync, active-high)
//            rcv_data_ready / rcv_data  - start strobe and input block
//            encrypt, cbc_en, key       - latched on the accepting edge
//            iv_load / iv               - chain register load (IDLE only)
//            handshake_ack              - consumer took trans_data (DONE only)
//            trans_data / trans_data_ready - result block and its valid flag
//            busy                       - high while in ROUND or DONE
// Revision : 1.0 - initial release
// ============================================================================
module feistel_block_core #(
    parameter int BLOCK_W    = 64,
    parameter int NUM_ROUNDS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rcv_data_ready,
    input  logic [BLOCK_W-1:0]   rcv_data,
    input  logic                 encrypt,
    input  logic                 cbc_en,
    input  logic [BLOCK_W/2-1:0] key,
    input  logic                 iv_load,
    input  logic [BLOCK_W-1:0]   iv,
    input  logic                 handshake_ack,
    output logic [BLOCK_W-1:0]   trans_data,
    output logic                 trans_data_ready,
    output logic                 busy
);

    localparam int HALF_W = BLOCK_W / 2;
    localparam int CNT_W  = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [HALF_W-1:0]   r_l;
    logic [HALF_W-1:0]   r_r;
    logic [HALF_W-1:0]   r_key;
    logic [BLOCK_W-1:0]  r_blk;
    logic [BLOCK_W-1:0]  r_chain;
    logic [BLOCK_W-1:0]  r_trans_data;
    logic                r_trans_ready;
    logic                r_enc;
    logic                r_cbc;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_last;
    logic [BLOCK_W-1:0]  w_chain_eff;
    logic [BLOCK_W-1:0]  w_core_in;
    logic [BLOCK_W-1:0]  w_core_out;
    logic [BLOCK_W-1:0]  w_result;
    logic [HALF_W-1:0]   w_rk;
    logic [HALF_W-1:0]   w_f;
    logic [HALF_W-1:0]   w_r_next;
    int                  w_step;
    int                  w_j;

    // Rotate left by 0..HALF_W-1: shift a doubled copy and keep the top half.
    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v, input int s);
        logic [2*HALF_W-1:0] d;
        d = {v, v} << s;
        return d[2*HALF_W-1:HALF_W];
    endfunction

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last = (r_cnt == CNT_W'(NUM_ROUNDS - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (rcv_data_ready) w_state_next = S_ROUND;
            S_ROUND: if (w_last)         w_state_next = S_DONE;
            S_DONE:  if (handshake_ack)  w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    // Decrypt walks the key schedule backwards so the same datapath inverts.
    always_comb begin
        w_step = int'(r_cnt);
        w_j    = r_enc ? w_step : (NUM_ROUNDS - 1 - w_step);
        w_rk   = rotl(r_key, w_j % HALF_W);
    end

    assign w_f        = {r_r[HALF_W-2:0], r_r[HALF_W-1]} ^ w_rk;
    assign w_r_next   = r_l ^ w_f;
    // Output after the final round is {R_n, L_n}; L_n equals the current R.
    assign w_core_out = {w_r_next, r_r};
    assign w_result   = (r_cbc && !r_enc) ? (w_core_out ^ r_chain) : w_core_out;

    // An IV loaded on the same edge as a start is the chain value that block uses.
    assign w_chain_eff = iv_load ? iv : r_chain;
    assign w_core_in   = (cbc_en && encrypt) ? (rcv_data ^ w_chain_eff) : rcv_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_l           <= '0;
            r_r           <= '0;
            r_key         <= '0;
            r_blk         <= '0;
            r_chain       <= '0;
            r_trans_data  <= '0;
            r_trans_ready <= 1'b0;
            r_enc         <= 1'b0;
            r_cbc         <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iv_load) begin
                        r_chain <= iv;
                    end
                    if (rcv_data_ready) begin
                        r_enc <= encrypt;
                        r_cbc <= cbc_en;
                        r_key <= key;
                        r_blk <= rcv_data;
                        r_cnt <= '0;
                        r_l   <= w_core_in[BLOCK_W-1:HALF_W];
                        r_r   <= w_core_in[HALF_W-1:0];
                    end
                end
                S_ROUND: begin
                    r_l   <= r_r;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_trans_data  <= w_result;
                        r_trans_ready <= 1'b1;
                        if (r_cbc) begin
                            // Next block chains from this ciphertext in both directions.
                            r_chain <= r_enc ? w_core_out : r_blk;
                        end
                    end
                end
                S_DONE: begin
                    if (handshake_ack) begin
                        r_trans_ready <= 1'b0;
                    end
                end
                default: begin
                    r_trans_ready <= 1'b0;
                end
            endcase
        end
    end

    assign trans_data       = r_trans_data;
    assign trans_data_ready = r_trans_ready;
    assign busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire
